lcd_hd44780_ctrl: RTL

//  HD44780 character-LCD bus sequencer for the DE2 board, on the CPU clock (1 MHz divided clock).

---
 rtl/lcd_pkg.sv | 43 ++++
 rtl/lcd_delay_timer.sv | 41 ++++
 rtl/lcd_hd44780_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared HD44780 LCD definitions (bus bit positions, init ROM, FSM states)
// Used by the LCD bus sequencer and by the CPU LCD register peripheral so both agree
// on the 32-bit LCD bus packing: [7:0] DATA, [8] RW, [9] RS, [10] EN, [31] ON.
package lcd_pkg;

    localparam int LCD_DATA_LSB = 0;
    localparam int RW_BIT       = 8;
    localparam int RS_BIT       = 9;
    localparam int EN_BIT       = 10;
    localparam int ON_BIT       = 31;

    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_HOME     = 8'h02;
    // Bit 0 of the home command is don't-care, so 0x03 is also a home.
    localparam logic [7:0] CMD_HOME_ALT = 8'h03;

    localparam int INIT_LEN = 4;
    // Entry 0 is sent first: 8-bit/2-line, display on, clear, entry mode increment.
    localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {8'h06, 8'h01, 8'h0C, 8'h38};

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT_LOAD,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT
    } lcd_state_e;

    // Clear and home need the long execution wait; only as commands (RS=0).
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == CMD_CLEAR || data == CMD_HOME || data == CMD_HOME_ALT);
    endfunction

    // WAIT-state load value for an execution wait of 'cycles'. WAIT itself runs
    // cycles-1 cycles; the INIT_LOAD or IDLE cycle that follows completes the wait,
    // which lets a back-to-back write be accepted with no extra bubble.
    function automatic int wait_load(input int cycles);
        return (cycles > 2) ? cycles - 2 : 0;
    endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// rtl/lcd_delay_timer.sv - loadable down-counter for LCD bus phase timing
// Ports:
//   i_clk      clock
//   i_reset    synchronous active-high reset, reloads RST_VAL
//   i_load     load strobe, takes i_load_val on this edge
//   i_load_val value loaded (phase length minus one)
//   o_done     count has reached zero
module lcd_delay_timer #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_done = (cnt_q == '0);

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// rtl/lcd_hd44780_ctrl.sv - HD44780 bus sequencer: power-up init, then EN/RS/DATA timing per byte write
// Ports:
//   i_clk        clock
//   i_reset      synchronous active-high reset
//   i_valid      write request
//   o_ready      write accepted on an edge where i_valid && o_ready
//   i_rs         0 = command, 1 = data
//   i_data       byte to write
//   o_lcd        packed LCD bus: [7:0] DATA, [8] RW (always 0), [9] RS, [10] EN, [31] ON
//   o_init_done  init sequence finished, sticky until reset
module lcd_hd44780_ctrl
    import lcd_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 1_000_000,
    parameter int T_PWRUP_US  = 15000,
    parameter int T_EXEC_US   = 40,
    parameter int T_CLR_US    = 1640
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_rs,
    input  logic [7:0]  i_data,
    output logic [31:0] o_lcd,
    output logic        o_init_done
);

    localparam int CYC_PER_US = (CLK_FREQ_HZ / 1_000_000 > 1) ? CLK_FREQ_HZ / 1_000_000 : 1;
    localparam int PULSE_CYC  = CYC_PER_US;
    localparam int PWRUP_CYC  = (T_PWRUP_US * CYC_PER_US > 1) ? T_PWRUP_US * CYC_PER_US : 1;
    localparam int EXEC_CYC   = T_EXEC_US * CYC_PER_US;
    localparam int CLR_CYC    = T_CLR_US * CYC_PER_US;

    localparam int MAX_A   = (PWRUP_CYC > CLR_CYC) ? PWRUP_CYC : CLR_CYC;
    localparam int MAX_B   = (EXEC_CYC > PULSE_CYC) ? EXEC_CYC : PULSE_CYC;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] PWRUP_LOAD = CNT_W'(PWRUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] EXEC_LOAD  = CNT_W'(wait_load(EXEC_CYC));
    localparam logic [CNT_W-1:0] CLR_LOAD   = CNT_W'(wait_load(CLR_CYC));
    localparam logic [1:0]       INIT_LAST  = 2'(INIT_LEN - 1);

    lcd_state_e       state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [7:0]       data_q, data_d;
    logic             rs_q, rs_d;
    logic             init_done_q, init_done_d;
    logic             en_q;
    logic             on_q;
    logic             ready_q;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_done;

    // Reset reloads the power-up delay, so PWRUP needs no separate entry load.
    lcd_delay_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (PWRUP_LOAD)
    ) u_timer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (tmr_load),
        .i_load_val (tmr_val),
        .o_done     (tmr_done)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        data_d      = data_q;
        rs_d        = rs_q;
        init_done_d = init_done_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        case (state_q)
            ST_PWRUP: begin
                if (tmr_done) begin
                    state_d = ST_INIT_LOAD;
                end
            end
            ST_INIT_LOAD: begin
                data_d  = INIT_ROM[idx_q];
                rs_d    = 1'b0;
                state_d = ST_SETUP;
            end
            ST_IDLE: begin
                if (i_valid && ready_q) begin
                    data_d  = i_data;
                    rs_d    = i_rs;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d  = ST_PULSE;
                tmr_load = 1'b1;
                tmr_val  = PULSE_LOAD;
            end
            ST_PULSE: begin
                if (tmr_done) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                state_d  = ST_WAIT;
                tmr_load = 1'b1;
                tmr_val  = is_long_cmd(rs_q, data_q) ? CLR_LOAD : EXEC_LOAD;
            end
            ST_WAIT: begin
                if (tmr_done) begin
                    if (init_done_q) begin
                        state_d = ST_IDLE;
                    end else if (idx_q == INIT_LAST) begin
                        state_d     = ST_IDLE;
                        init_done_d = 1'b1;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ST_INIT_LOAD;
                    end
                end
            end
            default: begin
                state_d = ST_PWRUP;
            end
        endcase
    end

    // Bus outputs are registered from next-state values so EN/RS/DATA change
    // on the same edge as the state they belong to.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_PWRUP;
            idx_q       <= '0;
            data_q      <= '0;
            rs_q        <= 1'b0;
            init_done_q <= 1'b0;
            en_q        <= 1'b0;
            on_q        <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            rs_q        <= rs_d;
            init_done_q <= init_done_d;
            en_q        <= (state_d == ST_PULSE);
            on_q        <= 1'b1;
            ready_q     <= (state_d == ST_IDLE);
        end
    end

    always_comb begin
        o_lcd                      = '0;
        o_lcd[LCD_DATA_LSB +: 8]   = data_q;
        o_lcd[RW_BIT]              = 1'b0;
        o_lcd[RS_BIT]              = rs_q;
        o_lcd[EN_BIT]              = en_q;
        o_lcd[ON_BIT]              = on_q;
    end

    assign o_ready     = ready_q;
    assign o_init_done = init_done_q;

endmodule
